// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and default sizing for the FIFO push arbiter and its round-robin picker.
package DataTypes;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef logic bit_t;
    typedef logic [DEF_DATA_W-1:0] fifo_in_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Rotating-priority search: the first set req bit at or after rr_ptr (wrapping) wins.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int OWN_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWN_W-1:0]   rr_ptr,
    output logic [OWN_W-1:0]   winner,
    output logic               valid
);

    // Scan from farthest to nearest so the nearest set bit overwrites the others.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                winner = OWN_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares the circularfifo write port among NUM_REQ producers: round-robin grants,
// bursts of up to MAX_BURST words, stalls on fifo_full. busy exposes the FSM state.
// Handshake: a requester holds req/last/data until it sees ack; ack marks the word pushed.
module fifo_push_arbiter
    import DataTypes::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    localparam int OWN_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        last,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic                      fifo_full,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      busy,
    output logic [OWN_W-1:0]          owner
);

    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    arb_state_e       state, state_nx;
    logic [OWN_W-1:0] rr_ptr, rr_nx;
    logic [OWN_W-1:0] owner_q, owner_nx;
    logic [OWN_W-1:0] owner_inc;
    logic [CNT_W-1:0] burst_cnt, cnt_nx;
    logic [OWN_W-1:0] winner;
    logic             win_valid;
    logic             in_burst;
    logic             owner_req;
    logic             owner_last;
    logic             accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWN_W   (OWN_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    // Reset gates the outputs so nothing is pushed in the reset cycle itself.
    assign in_burst   = (state == BURST) && !reset;
    assign owner_req  = req[owner_q];
    assign owner_last = last[owner_q];
    assign accept     = in_burst && owner_req && !fifo_full;
    assign owner_inc  = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner      = owner_q;
    assign busy       = in_burst;
    assign fifo_push  = accept;

    always_comb begin
        ack       = '0;
        fifo_data = '0;
        if (accept) begin
            ack[owner_q] = 1'b1;
            fifo_data    = data_in[int'(owner_q)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        owner_nx = owner_q;
        cnt_nx   = burst_cnt;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    owner_nx = winner;
                    cnt_nx   = '0;
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    state_nx = IDLE;
                    rr_nx    = owner_inc;
                end else if (accept) begin
                    cnt_nx = burst_cnt + 1'b1;
                    if (owner_last || burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nx = IDLE;
                        rr_nx    = owner_inc;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner_q   <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            owner_q   <= owner_nx;
            burst_cnt <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: producers react to ack, a monitor pops a
// queue of expected {gap, requester, word} entries on every push.
module tb_fifo_push_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int OWN_W   = 2;
    localparam int EW      = 16;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        last;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic                      fifo_full;
    logic [NUM_REQ-1:0]        ack;
    logic                      fifo_push;
    logic [DATA_W-1:0]         fifo_data;
    logic                      busy;
    logic [OWN_W-1:0]          owner;

    fifo_push_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .data_in   (data_in),
        .fifo_full (fifo_full),
        .ack       (ack),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .busy      (busy),
        .owner     (owner)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [EW-1:0]      exp_q[$];
    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;
    int                 last_cyc = 0;
    int                 push_cnt = 0;
    logic [NUM_REQ-1:0] ack_d = '0;

    // directed-check requests handed from the driver to the monitor
    int    chk_seq = 0;
    int    done_seq = 0;
    string c_name = "";
    string c_fail = "";
    int    c_busy, c_push, c_owner, c_rr;

    // producer model
    int                 rem[NUM_REQ];
    logic [DATA_W-1:0]  dw[NUM_REQ];
    logic [NUM_REQ-1:0] last_cfg;
    logic               inc;

    function automatic void check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic logic [EW-1:0] mk(int gap, int idx, logic [DATA_W-1:0] d);
        return {4'(gap), 4'(idx), d};
    endfunction

    // monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        cyc++;
        ack_d = reset ? '0 : ack;
        if (chk_seq != done_seq) begin
            done_seq = chk_seq;
            if (c_fail != "") begin
                total++;
                bad++;
                $display("FAIL %s: bound expired, got=pending want=done", c_fail);
            end else begin
                check({c_name, "_busy"}, int'(busy), c_busy);
                check({c_name, "_push"}, int'(fifo_push), c_push);
                if (c_push == 0) begin
                    check({c_name, "_ack"}, int'(ack), 0);
                    check({c_name, "_data"}, int'(fifo_data), 0);
                end
                if (c_owner >= 0) check({c_name, "_owner"}, int'(owner), c_owner);
                if (c_rr >= 0) check({c_name, "_rr_ptr"}, int'(dut.rr_ptr), c_rr);
            end
        end
        if (!reset) begin
            check("full_guard", int'(fifo_push & fifo_full), 0);
            if (fifo_push) begin
                push_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_push: got=0x%0h want=none", fifo_data);
                end else begin
                    e = exp_q.pop_front();
                    check("push_data", int'(fifo_data), int'(e[7:0]));
                    check("push_ack", int'(ack), 1 << e[11:8]);
                    check("push_owner", int'(owner), int'(e[11:8]));
                    if (e[15:12] != 0) check("push_gap", cyc - last_cyc, int'(e[15:12]));
                end
                last_cyc = cyc;
            end else begin
                check("ack_without_push", int'(ack), 0);
            end
        end
    end

    // driver tasks
    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]                  = (rem[i] != 0);
            last[i]                 = last_cfg[i];
            data_in[i*DATA_W +: DATA_W] = dw[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_d[i]) begin
                rem[i]--;
                if (inc) dw[i] = dw[i] + 8'd1;
            end
        end
        apply();
    endtask

    task automatic expect_state(string name, int b, int p, int o, int rr);
        c_name  = name;
        c_busy  = b;
        c_push  = p;
        c_owner = o;
        c_rr    = rr;
        chk_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic fail_req(string name);
        c_fail = name;
        chk_seq++;
        @(negedge clk);
        #1;
        c_fail = "";
    endtask

    task automatic wait_pushes(int n, string name);
        for (int t = 0; t < 40 && push_cnt < n; t++) step();
        if (push_cnt < n) fail_req(name);
    endtask

    task automatic drain(string name);
        for (int t = 0; t < 60; t++) begin
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        if (exp_q.size() != 0 || busy) fail_req(name);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // reset with every requester asserted; rotation A0..A3 then A0 again
        reset     = 1'b1;
        fifo_full = 1'b0;
        inc       = 1'b0;
        last_cfg  = 4'b1111;
        dw[0] = 8'hA0; dw[1] = 8'hA1; dw[2] = 8'hA2; dw[3] = 8'hA3;
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        apply();
        expect_state("reset_c0", 0, 0, 0, 0);
        step();
        expect_state("reset_c1", 0, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 8'hA0));
        exp_q.push_back(mk(2, 1, 8'hA1));
        exp_q.push_back(mk(2, 2, 8'hA2));
        exp_q.push_back(mk(2, 3, 8'hA3));
        exp_q.push_back(mk(2, 0, 8'hA0));
        reset = 1'b0;
        drain("drain_rotation");

        // burst cap: requester 2 alone, 8 words in 10 cycles
        inc      = 1'b1;
        last_cfg = 4'b0000;
        dw[2]    = 8'h20;
        rem[2]   = 8;
        apply();
        exp_q.push_back(mk(0, 2, 8'h20));
        exp_q.push_back(mk(1, 2, 8'h21));
        exp_q.push_back(mk(1, 2, 8'h22));
        exp_q.push_back(mk(1, 2, 8'h23));
        exp_q.push_back(mk(2, 2, 8'h24));
        exp_q.push_back(mk(1, 2, 8'h25));
        exp_q.push_back(mk(1, 2, 8'h26));
        exp_q.push_back(mk(1, 2, 8'h27));
        drain("drain_burst_cap");

        // full stall of 3 cycles after 2 pushes
        dw[0]  = 8'h30;
        rem[0] = 4;
        apply();
        exp_q.push_back(mk(0, 0, 8'h30));
        exp_q.push_back(mk(1, 0, 8'h31));
        exp_q.push_back(mk(4, 0, 8'h32));
        exp_q.push_back(mk(1, 0, 8'h33));
        base = push_cnt;
        wait_pushes(base + 2, "wait_stall");
        fifo_full = 1'b1;
        repeat (3) begin
            expect_state("stall", 1, 0, 0, -1);
            step();
        end
        fifo_full = 1'b0;
        drain("drain_stall");

        // withdrawal: owner 1 drops after one word, requester 3 takes over
        last_cfg = 4'b1000;
        dw[1] = 8'h41; rem[1] = 1;
        dw[3] = 8'h43; rem[3] = 1;
        apply();
        exp_q.push_back(mk(0, 1, 8'h41));
        exp_q.push_back(mk(3, 3, 8'h43));
        base = push_cnt;
        wait_pushes(base + 1, "wait_withdraw");
        expect_state("withdraw", 1, 0, 1, -1);
        step();
        expect_state("after_withdraw", 0, 0, 1, 2);
        drain("drain_withdraw");

        // reset in the cycle owner 2 would push its third word
        last_cfg = 4'b0000;
        dw[2]  = 8'h50;
        rem[2] = 4;
        apply();
        exp_q.push_back(mk(0, 2, 8'h50));
        exp_q.push_back(mk(1, 2, 8'h51));
        exp_q.push_back(mk(3, 2, 8'h52));
        exp_q.push_back(mk(1, 2, 8'h53));
        base = push_cnt;
        wait_pushes(base + 2, "wait_reset_mid");
        reset = 1'b1;
        expect_state("reset_mid", 0, 0, -1, -1);
        step();
        reset = 1'b0;
        expect_state("after_reset", 0, 0, 0, 0);
        drain("drain_reset_mid");

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
